rr_sel_mux: RTL

Parametrised, registered N-to-1 select unit with per-channel valid/ready handshakes and selectable fixed-priority or round-robin arbitration. It sits in the SIMD DLX datapath wherever several lanes or sources compete for one shared sink: write-back destination and data, register-address forwarding, result merge. It generalises the plain 2:1 5-bit select to a buffered, flow-controlled, fair arbiter.

---
 rtl/dlx_defs.sv | 18 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/rr_sel_mux.sv | 73 +++++++
 3 files changed

// File: rtl/dlx_defs.sv
// Shared definitions for the DLX select/arbitration units.
package dlx_defs;

  // Arbitration mode encodings
  localparam logic SEL_MODE_FIXED = 1'b0;
  localparam logic SEL_MODE_RR    = 1'b1;

  // Ceiling log2, usable in parameter/localparam expressions
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational fixed-priority / round-robin arbiter.
// The search is a double-width priority encoder: the low half holds the
// requests at or above the start pointer, the high half holds all requests,
// so the lowest set bit is the first requester at/after the pointer with wrap.
module rr_arbiter
  import dlx_defs::*;
#(
  parameter  int CHANNELS = 4,
  localparam int CH_W     = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] REQ,
  input  logic                MODE,
  input  logic [CH_W-1:0]     PTR,
  output logic [CHANNELS-1:0] GRANT,
  output logic [CH_W-1:0]     GNT_IDX,
  output logic                ANY
);

  logic [CH_W-1:0]       w_base;
  logic [CHANNELS-1:0]   w_lo;
  logic [2*CHANNELS-1:0] w_dbl;

  // Fixed priority is round-robin with the search pinned to channel 0
  always_comb begin
    w_base = (MODE == SEL_MODE_FIXED) ? '0 : PTR;
    w_lo   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_lo[i] = REQ[i] && (CH_W'(i) >= w_base);
    end
    w_dbl = {REQ, w_lo};
  end

  // Lowest set bit of the double-width vector wins; fold back modulo CHANNELS
  always_comb begin
    ANY     = 1'b0;
    GNT_IDX = '0;
    for (int i = 2*CHANNELS-1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        ANY     = 1'b1;
        GNT_IDX = CH_W'(i % CHANNELS);
      end
    end
  end

  // One-hot grant from the encoded index
  always_comb begin
    GRANT = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      GRANT[j] = ANY && (GNT_IDX == CH_W'(j));
    end
  end

endmodule

// File: rtl/rr_sel_mux.sv
// Registered N-to-1 select with valid/ready handshakes on every channel and
// a single-entry output register. Arbitration is fixed priority or
// round-robin; the round-robin pointer only advances on RR-mode accepts.
// Legal CHANNELS range is 2..16.
module rr_sel_mux
  import dlx_defs::*;
#(
  parameter  int WIDTH    = 5,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      MODE,
  input  logic [CHANNELS-1:0]       IN_VALID,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  output logic [CHANNELS-1:0]       IN_READY,
  output logic                      O_VALID,
  output logic [WIDTH-1:0]          O_DATA,
  output logic [CH_W-1:0]           O_CH,
  input  logic                      O_READY
);

  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     r_ptr;

  logic [CHANNELS-1:0] w_grant;
  logic [CH_W-1:0]     w_idx;
  logic                w_any;
  logic                w_free;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .REQ     (IN_VALID),
    .MODE    (MODE),
    .PTR     (r_ptr),
    .GRANT   (w_grant),
    .GNT_IDX (w_idx),
    .ANY     (w_any)
  );

  // Register is free when empty or being drained this cycle; RESET masks
  // ready so nothing is offered while the block is held in reset
  always_comb begin
    w_free   = (~r_valid | O_READY) & ~RESET;
    IN_READY = w_free ? w_grant : '0;
  end

  // Output register and round-robin pointer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else if (w_free) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= IN_DATA[w_idx*WIDTH +: WIDTH];
        r_ch   <= w_idx;
        if (MODE == SEL_MODE_RR) begin
          r_ptr <= (w_idx == CH_W'(CHANNELS-1)) ? '0 : w_idx + 1'b1;
        end
      end
    end
  end

  assign O_VALID = r_valid;
  assign O_DATA  = r_data;
  assign O_CH    = r_ch;

endmodule
